bcd_time_entry: RTL and testbench
=================================

BCD_TIME_ENTRY -- requirements
Module: bcd_time_entry

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: begin a new entry sequence.
REQ-004 The block SHALL have the port cancel, input, 1 bit: abort the entry in progress.
REQ-005 The block SHALL have the port digit_valid, input, 1 bit: digit carries one keyed BCD digit this cycle.
REQ-006 The block SHALL have the port digit, input, 4 bits: BCD digit value, qualified by digit_valid.
REQ-007 The block SHALL have the port hour, output, 5 bits: binary hour 0..23, held between commits.
REQ-008 The block SHALL have the port min, output, 6 bits: binary minute 0..59, held between commits.
REQ-009 The block SHALL have the port sec, output, 6 bits: binary second 0..59, held between commits.
REQ-010 The block SHALL have the port set_valid, output, 1 bit: one-cycle pulse; hour/min/sec hold a new committed time.
REQ-011 The block SHALL have the port digit_err, output, 1 bit: one-cycle pulse; the offered digit was rejected.
REQ-012 The block SHALL have the port busy, output, 1 bit: high while an entry is in progress.
REQ-013 The block SHALL have the port cur_pos, output, 3 bits: digit position awaited (0=h_ten .. 5=s_one, 7=idle), used for display blinking.

Function
REQ-014 The FSM SHALL use these states: IDLE, H_TEN, H_ONE, M_TEN, M_ONE, S_TEN, S_ONE, COMMIT.
REQ-015 In IDLE, start=1 SHALL move the FSM to H_TEN; digit_valid SHALL be ignored in IDLE and SHALL NOT pulse digit_err.
REQ-016 In each digit state, an accepted digit SHALL be latched and the FSM SHALL advance one state on the next edge.
REQ-017 The digit rule SHALL be: digit>9 is rejected in every digit state.
REQ-018 The tens rule SHALL be: h_ten>2 is rejected, and m_ten>5 or s_ten>5 is rejected.
REQ-019 The hour rule SHALL be: at H_ONE, a digit is rejected if h_ten*10+digit > 23.
REQ-020 A rejected digit SHALL pulse digit_err for exactly one cycle, leave the FSM state unchanged and latch nothing.
REQ-021 Conversion SHALL compute value = ten*8 + ten*2 + one in 7-bit arithmetic and truncate the result to the output width.
REQ-022 COMMIT SHALL update hour/min/sec and pulse set_valid on the same edge, then return to IDLE, giving 1-cycle latency from acceptance of s_one.
REQ-023 hour/min/sec SHALL change only at COMMIT or reset; a cancelled or partial entry SHALL never alter them.
REQ-024 cancel SHALL return the FSM to IDLE from any state except COMMIT, with no set_valid.
REQ-025 cancel SHALL take priority over digit_valid and start in the same cycle.
REQ-026 start while busy (and without cancel) SHALL restart the entry at H_TEN and discard latched digits.
REQ-027 busy SHALL be 1 in states H_TEN through COMMIT; cur_pos SHALL be 7 in IDLE and COMMIT.

Reset
REQ-028 On rst=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-entry.
REQ-029 On reset, hour, min and sec SHALL be 0; set_valid, digit_err and busy SHALL be 0; cur_pos SHALL be 7.
REQ-030 rst SHALL override all other inputs.

Configuration
REQ-031 When macro TIME_ENTRY_12H_EN is defined, the block SHALL add input pm (1 bit) and enter the hour as 01..12.
REQ-032 With TIME_ENTRY_12H_EN, h_ten>1 SHALL be rejected, and h_one SHALL be rejected when the hour would be 00 or >12.
REQ-033 With TIME_ENTRY_12H_EN, pm SHALL be sampled at COMMIT and mapped as: 12AM->0, 12PM->12, otherwise h+12*pm.
REQ-034 Without TIME_ENTRY_12H_EN, the pm port SHALL be absent and 24-hour rules REQ-018/REQ-019 SHALL apply.

Structure
REQ-035 Package time_entry_pkg SHALL hold the state enum and the constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59, HOUR12_MAX=12 and POS_IDLE=7.
REQ-036 Combinational sub-module bcd2_to_bin SHALL convert (ten, one) to 7-bit binary and SHALL be instantiated three times.

Verification
REQ-037 The bench SHALL check: start, then digits 2,3,5,9,5,9 -> set_valid 1 cycle after the last digit, hour=23, min=59, sec=59.
REQ-038 The bench SHALL check: start, then digits 2,4 -> digit_err on the '4', cur_pos stays 1; then 0,1,0,0,0 -> hour=20, min=10, sec=0.
REQ-039 The bench SHALL check: start, then digits 1,2,6 -> digit_err on the '6' (m_ten>5); then cancel -> IDLE, outputs unchanged, no set_valid.
REQ-040 The bench SHALL check: digit_valid and cancel in the same cycle at M_ONE -> IDLE, no latch; rst asserted at S_TEN -> all outputs at reset values.
REQ-041 The bench SHALL check: with TIME_ENTRY_12H_EN, digits 1,2,0,0,0,0 with pm=0 -> hour=0; the same digits with pm=1 -> hour=12; 0,0 -> digit_err on the second '0'.

Source files
------------

// File: rtl/time_entry_pkg.sv
// ============================================================================
// Module : time_entry_pkg
// Brief  : Shared state encoding, time limits and BCD helper for bcd_time_entry
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package time_entry_pkg;

  // Digit states are numbered so that cur_pos = state - 1.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    H_TEN  = 3'd1,
    H_ONE  = 3'd2,
    M_TEN  = 3'd3,
    M_ONE  = 3'd4,
    S_TEN  = 3'd5,
    S_ONE  = 3'd6,
    COMMIT = 3'd7
  } state_t;

  localparam logic [6:0] HOUR_MAX   = 7'd23;
  localparam logic [6:0] MIN_MAX    = 7'd59;
  localparam logic [6:0] SEC_MAX    = 7'd59;
  localparam logic [6:0] HOUR12_MAX = 7'd12;
  localparam logic [2:0] POS_IDLE   = 3'd7;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] H_TEN_MAX_24 = 4'd2;
  localparam logic [3:0] H_TEN_MAX_12 = 4'd1;
  localparam logic [3:0] MS_TEN_MAX   = 4'd5;

  function automatic logic [6:0] bcd_value(input logic [3:0] ten, input logic [3:0] one);
    return ({3'b000, ten} << 3) + ({3'b000, ten} << 1) + {3'b000, one};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2_to_bin.sv
// ============================================================================
// Module : bcd2_to_bin
// Brief  : Combinational two-digit BCD to 7-bit binary converter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd2_to_bin (
  input  logic [3:0] ten,
  input  logic [3:0] one,
  output logic [6:0] value
);

  logic [6:0] ten_w;
  logic [6:0] one_w;

  assign ten_w = {3'b000, ten};
  assign one_w = {3'b000, one};
  // ten*10 built from shifts to stay adder-only.
  assign value = (ten_w << 3) + (ten_w << 1) + one_w;

endmodule

`default_nettype wire

// File: rtl/bcd_time_entry.sv
// ============================================================================
// Module : bcd_time_entry
// Brief  : Keyed hh:mm:ss entry FSM with digit validation and atomic commit.
//          Define TIME_ENTRY_12H_EN for 01..12 hour entry with a pm input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_time_entry
  import time_entry_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic       digit_valid,
  input  logic [3:0] digit,
`ifdef TIME_ENTRY_12H_EN
  input  logic       pm,
`endif
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       set_valid,
  output logic       digit_err,
  output logic       busy,
  output logic [2:0] cur_pos
);

  state_t     state;
  logic [3:0] h_ten, h_one, m_ten, m_one, s_ten, s_one;
  logic [6:0] hour_bin, min_bin, sec_bin, hour_next, hour_try;
  logic       accept;

  bcd2_to_bin u_hour (.ten(h_ten), .one(h_one), .value(hour_bin));
  bcd2_to_bin u_min  (.ten(m_ten), .one(m_one), .value(min_bin));
  bcd2_to_bin u_sec  (.ten(s_ten), .one(s_one), .value(sec_bin));

  assign hour_try = bcd_value(h_ten, digit);

`ifdef TIME_ENTRY_12H_EN
  logic [6:0] pm_add;
  assign pm_add    = pm ? HOUR12_MAX : 7'd0;
  // 12 is the only hour whose AM value is not itself.
  assign hour_next = (hour_bin == HOUR12_MAX) ? pm_add : hour_bin + pm_add;
`else
  assign hour_next = hour_bin;
`endif

  always_comb begin
    accept = 1'b0;
    if (digit_valid && (digit <= DIGIT_MAX)) begin
      case (state)
`ifdef TIME_ENTRY_12H_EN
        H_TEN:        accept = (digit <= H_TEN_MAX_12);
        H_ONE:        accept = (hour_try != 7'd0) && (hour_try <= HOUR12_MAX);
`else
        H_TEN:        accept = (digit <= H_TEN_MAX_24);
        H_ONE:        accept = (hour_try <= HOUR_MAX);
`endif
        M_TEN, S_TEN: accept = (digit <= MS_TEN_MAX);
        M_ONE, S_ONE: accept = 1'b1;
        default:      accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hour      <= 5'd0;
      min       <= 6'd0;
      sec       <= 6'd0;
      set_valid <= 1'b0;
      digit_err <= 1'b0;
      h_ten     <= 4'd0;
      h_one     <= 4'd0;
      m_ten     <= 4'd0;
      m_one     <= 4'd0;
      s_ten     <= 4'd0;
      s_one     <= 4'd0;
    end else begin
      set_valid <= 1'b0;
      digit_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!cancel && start) begin
            state <= H_TEN;
            h_ten <= 4'd0;
            h_one <= 4'd0;
            m_ten <= 4'd0;
            m_one <= 4'd0;
            s_ten <= 4'd0;
            s_one <= 4'd0;
          end
        end
        COMMIT: begin
          hour      <= hour_next[4:0];
          min       <= min_bin[5:0];
          sec       <= sec_bin[5:0];
          set_valid <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          if (cancel) begin
            state <= IDLE;
          end else if (start) begin
            state <= H_TEN;
            h_ten <= 4'd0;
            h_one <= 4'd0;
            m_ten <= 4'd0;
            m_one <= 4'd0;
            s_ten <= 4'd0;
            s_one <= 4'd0;
          end else if (digit_valid) begin
            if (accept) begin
              case (state)
                H_TEN:   h_ten <= digit;
                H_ONE:   h_one <= digit;
                M_TEN:   m_ten <= digit;
                M_ONE:   m_one <= digit;
                S_TEN:   s_ten <= digit;
                default: s_one <= digit;
              endcase
              state <= state_t'(state + 3'd1);
            end else begin
              digit_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign cur_pos = ((state == IDLE) || (state == COMMIT)) ? POS_IDLE : (state - 3'd1);

  // Limits bound the values to the output widths; upper bits are always zero.
  logic unused_bits;
  assign unused_bits = &{1'b0, hour_next[6:5], min_bin[6], sec_bin[6]};

endmodule

`default_nettype wire

// File: tb/tb_bcd_time_entry.sv
// Self-checking bench for bcd_time_entry: directed cases plus random stimulus
// compared every cycle against a behavioural time-entry model.
`default_nettype none

module tb_bcd_time_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       pm = 1'b0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       set_valid;
  logic       digit_err;
  logic       busy;
  logic [2:0] cur_pos;

  always #5 clk = ~clk;

  bcd_time_entry dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cancel(cancel),
    .digit_valid(digit_valid),
    .digit(digit),
`ifdef TIME_ENTRY_12H_EN
    .pm(pm),
`endif
    .hour(hour),
    .min(min),
    .sec(sec),
    .set_valid(set_valid),
    .digit_err(digit_err),
    .busy(busy),
    .cur_pos(cur_pos)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_pos = -1 idle, 0..5 awaiting that digit, 6 = commit pending.
  int m_pos = -1;
  int m_d[6];
  int m_hour = 0, m_min = 0, m_sec = 0;
  bit m_sv = 1'b0, m_err = 1'b0;

  function automatic bit digit_ok(input int pos, input int dg, input int first);
    int hv;
    if (dg > 9) return 1'b0;
    hv = first * 10 + dg;
    case (pos)
`ifdef TIME_ENTRY_12H_EN
      0: return dg <= 1;
      1: return (hv >= 1) && (hv <= 12);
`else
      0: return dg <= 2;
      1: return hv <= 23;
`endif
      2, 4: return dg <= 5;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    int hv;
    m_sv  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_pos  = -1;
      m_hour = 0;
      m_min  = 0;
      m_sec  = 0;
    end else if (m_pos == 6) begin
      hv = m_d[0] * 10 + m_d[1];
`ifdef TIME_ENTRY_12H_EN
      if (hv == 12) hv = pm ? 12 : 0;
      else hv = hv + (pm ? 12 : 0);
`endif
      m_hour = hv;
      m_min  = m_d[2] * 10 + m_d[3];
      m_sec  = m_d[4] * 10 + m_d[5];
      m_sv   = 1'b1;
      m_pos  = -1;
    end else if (m_pos == -1) begin
      if (!cancel && start) m_pos = 0;
    end else if (cancel) begin
      m_pos = -1;
    end else if (start) begin
      m_pos = 0;
    end else if (digit_valid) begin
      if (digit_ok(m_pos, int'(digit), m_d[0])) begin
        m_d[m_pos] = int'(digit);
        m_pos++;
      end else begin
        m_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("hour", int'(hour), m_hour);
      check("min", int'(min), m_min);
      check("sec", int'(sec), m_sec);
      check("set_valid", int'(set_valid), int'(m_sv));
      check("digit_err", int'(digit_err), int'(m_err));
      check("busy", int'(busy), (m_pos != -1) ? 1 : 0);
      check("cur_pos", int'(cur_pos), (m_pos >= 0 && m_pos <= 5) ? m_pos : 7);
    end
  end

  task automatic drive(input bit r, input bit s, input bit c, input bit v, input int d);
    @(negedge clk);
    #1;
    rst         = r;
    start       = s;
    cancel      = c;
    digit_valid = v;
    digit       = 4'(d);
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic key(input int d);
    drive(1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic go();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int sel;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #1;
    check("rst_hour", int'(hour), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cur_pos", int'(cur_pos), 7);
    check("rst_set_valid", int'(set_valid), 0);

`ifndef TIME_ENTRY_12H_EN
    go(); key(2); key(3); key(5); key(9); key(5); key(9);
    nop();
    check("max_commit_pending_sv", int'(set_valid), 0);
    check("max_commit_busy", int'(busy), 1);
    check("max_commit_cur_pos", int'(cur_pos), 7);
    nop();
    check("max_sv", int'(set_valid), 1);
    check("max_hour", int'(hour), 23);
    check("max_min", int'(min), 59);
    check("max_sec", int'(sec), 59);
    nop();
    check("max_sv_drop", int'(set_valid), 0);
    check("max_hour_held", int'(hour), 23);

    go(); key(2); key(4); key(0);
    check("h24_err", int'(digit_err), 1);
    check("h24_cur_pos", int'(cur_pos), 1);
    key(1); key(0); key(0); key(0);
    nop(); nop();
    check("h20_sv", int'(set_valid), 1);
    check("h20_hour", int'(hour), 20);
    check("h20_min", int'(min), 10);
    check("h20_sec", int'(sec), 0);

    go(); key(1); key(2); key(6);
    nop();
    check("mten_err", int'(digit_err), 1);
    check("mten_cur_pos", int'(cur_pos), 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    nop();
    check("cancel_busy", int'(busy), 0);
    check("cancel_cur_pos", int'(cur_pos), 7);
    check("cancel_sv", int'(set_valid), 0);
    check("cancel_hour", int'(hour), 20);
    check("cancel_min", int'(min), 10);

    go(); key(1); key(2); key(3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4);
    nop();
    check("cancel_digit_busy", int'(busy), 0);
    check("cancel_digit_err", int'(digit_err), 0);
    go(); key(1); key(2); key(3); key(4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    nop();
    check("midrst_hour", int'(hour), 0);
    check("midrst_min", int'(min), 0);
    check("midrst_sec", int'(sec), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_cur_pos", int'(cur_pos), 7);
`else
    pm = 1'b0;
    go(); key(1); key(2); key(0); key(0); key(0); key(0);
    nop(); nop();
    check("am12_sv", int'(set_valid), 1);
    check("am12_hour", int'(hour), 0);
    pm = 1'b1;
    go(); key(1); key(2); key(0); key(0); key(0); key(0);
    nop(); nop();
    check("pm12_hour", int'(hour), 12);
    go(); key(0); key(0);
    nop();
    check("h00_err", int'(digit_err), 1);
    check("h00_cur_pos", int'(cur_pos), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    nop();
    check("h00_hour_held", int'(hour), 12);
`endif

    for (int i = 0; i < 4000; i++) begin
      pm  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 15));
      drive(($urandom_range(0, 399) == 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0),
            (sel < 14) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15)));
    end
    nop(); nop(); nop();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
